// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between PORTS requesters.
// One operation in flight at a time; a watchdog aborts operations whose
// result never arrives and reports ERR to the owning port instead.
module alu_req_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [PORTS-1:0]            req_i,
    input  logic [4*PORTS-1:0]          req_op_i,
    input  logic [2*PORTS-1:0]          req_movi_i,
    input  logic [DATA_WIDTH*PORTS-1:0] req_a_i,
    input  logic [DATA_WIDTH*PORTS-1:0] req_b_i,
    output logic [PORTS-1:0]            gnt_o,
    output logic [PORTS-1:0]            rsp_vld_o,
    output logic [DATA_WIDTH-1:0]       rsp_data_o,
    output logic [PORTS-1:0]            err_o,
    output logic                        busy_o,
    output logic                        act_o,
    output logic [3:0]                  op_o,
    output logic [1:0]                  movi_o,
    output logic [DATA_WIDTH-1:0]       reg_a_o,
    output logic [DATA_WIDTH-1:0]       reg_b_o,
    output logic [DATA_WIDTH-1:0]       mem_o,
    output logic [DATA_WIDTH-1:0]       imm_o,
    input  logic                        alu_rdy_i,
    input  logic [DATA_WIDTH-1:0]       ex_alu_i,
    input  logic                        ex_alu_vld_i
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [3:0]            op_q, op_d;
    logic [1:0]            movi_q, movi_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [PORTS-1:0]      rsp_vld_q, rsp_vld_d;
    logic [PORTS-1:0]      err_q, err_d;

    // Per-port views of the flattened request buses
    logic [3:0]            port_op   [PORTS];
    logic [1:0]            port_movi [PORTS];
    logic [DATA_WIDTH-1:0] port_a    [PORTS];
    logic [DATA_WIDTH-1:0] port_b    [PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_unpack
            assign port_op[gi]   = req_op_i[4*gi +: 4];
            assign port_movi[gi] = req_movi_i[2*gi +: 2];
            assign port_a[gi]    = req_a_i[DATA_WIDTH*gi +: DATA_WIDTH];
            assign port_b[gi]    = req_b_i[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    logic [PW-1:0] sel;
    logic          found;

    // Round-robin search: first pending port after ptr, wrapping around
    always_comb begin
        int unsigned   idx;
        logic [PW-1:0] idx_pw;
        sel    = ptr_q;
        found  = 1'b0;
        idx    = 0;
        idx_pw = '0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            idx    = (int'(ptr_q) + k) % PORTS;
            idx_pw = PW'(idx);
            if (!found && req_i[idx_pw]) begin
                found = 1'b1;
                sel   = idx_pw;
            end
        end
    end

    // Next-state and capture logic for the IDLE/ISSUE/WAIT sequencer
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        op_d       = op_q;
        movi_d     = movi_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = '0;
        err_d      = '0;
        case (state_q)
            S_IDLE: begin
                // ALU_RDY only matters here; a result arriving now is stray
                if (found && alu_rdy_i) begin
                    owner_d = sel;
                    ptr_d   = sel;
                    op_d    = port_op[sel];
                    movi_d  = port_movi[sel];
                    a_d     = port_a[sel];
                    b_d     = port_b[sel];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result on the timeout cycle still counts as a result
                if (ex_alu_vld_i) begin
                    rsp_data_d         = ex_alu_i;
                    rsp_vld_d[owner_q] = 1'b1;
                    state_d            = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any op in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(PORTS - 1);
            owner_q    <= '0;
            op_q       <= '0;
            movi_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            movi_q     <= movi_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
            err_q      <= err_d;
        end
    end

    // Grant and activate are decoded straight from the ISSUE state
    always_comb begin
        gnt_o = '0;
        if (state_q == S_ISSUE) begin
            gnt_o[owner_q] = 1'b1;
        end
    end

    assign act_o      = (state_q == S_ISSUE);
    assign busy_o     = (state_q != S_IDLE);
    assign op_o       = op_q;
    assign movi_o     = movi_q;
    assign reg_a_o    = a_q;
    assign reg_b_o    = b_q;
    assign mem_o      = b_q;
    assign imm_o      = b_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_vld_o  = rsp_vld_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: PORTS=4, DATA_WIDTH=8, TIMEOUT=8.
module tb_alu_req_arbiter;

    localparam int P  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [P-1:0]  req;
    logic [4*P-1:0] req_op;
    logic [2*P-1:0] req_movi;
    logic [DW*P-1:0] req_a;
    logic [DW*P-1:0] req_b;
    logic [P-1:0]  gnt, rsp_vld, err;
    logic [DW-1:0] rsp_data;
    logic          busy, act;
    logic [3:0]    op;
    logic [1:0]    movi;
    logic [DW-1:0] reg_a, reg_b, mem, imm;
    logic          alu_rdy;
    logic [DW-1:0] ex_alu;
    logic          ex_alu_vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_op_i(req_op),
        .req_movi_i(req_movi), .req_a_i(req_a), .req_b_i(req_b),
        .gnt_o(gnt), .rsp_vld_o(rsp_vld), .rsp_data_o(rsp_data), .err_o(err),
        .busy_o(busy), .act_o(act), .op_o(op), .movi_o(movi),
        .reg_a_o(reg_a), .reg_b_o(reg_b), .mem_o(mem), .imm_o(imm),
        .alu_rdy_i(alu_rdy), .ex_alu_i(ex_alu), .ex_alu_vld_i(ex_alu_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] o, input logic [1:0] m,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[4*p +: 4]     = o;
        req_movi[2*p +: 2]   = m;
        req_a[DW*p +: DW]    = a;
        req_b[DW*p +: DW]    = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_op = '0; req_movi = '0; req_a = '0; req_b = '0;
        alu_rdy = 1'b0; ex_alu = '0; ex_alu_vld = 1'b0;
        tick(); tick();
        if ({gnt, rsp_vld, err, busy, act} !== '0) begin
            $display("FAIL reset_ctrl got=%b want=0", {gnt, rsp_vld, err, busy, act}); errors++;
        end
        checks++;
        if ({op, movi, reg_a, reg_b, mem, imm, rsp_data} !== '0) begin
            $display("FAIL reset_data got=%h want=0", {op, movi, reg_a, reg_b, mem, imm, rsp_data}); errors++;
        end
        checks++;
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_single();
        set_port(2, 4'h1, 2'b01, 8'h05, 8'h03);
        req = 4'b0100; alu_rdy = 1'b1;
        tick();
        if (gnt !== 4'b0100 || act !== 1'b1) begin
            $display("FAIL single_gnt got=%b/%b want=0100/1", gnt, act); errors++;
        end
        checks++;
        if (op !== 4'h1 || movi !== 2'b01 || reg_a !== 8'h05 || reg_b !== 8'h03 || mem !== 8'h03 || imm !== 8'h03) begin
            $display("FAIL single_fields got=%h %h %h %h %h %h want=1 1 05 03 03 03", op, movi, reg_a, reg_b, mem, imm); errors++;
        end
        checks++;
        req = '0;
        tick(); tick(); tick();
        if (act !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL single_wait got act=%b busy=%b want act=0 busy=1", act, busy); errors++;
        end
        checks++;
        ex_alu_vld = 1'b1; ex_alu = 8'h08;
        tick();
        ex_alu_vld = 1'b0; ex_alu = 8'hEE;
        if (rsp_vld !== 4'b0100 || rsp_data !== 8'h08 || err !== '0 || busy !== 1'b0) begin
            $display("FAIL single_rsp got vld=%b data=%h err=%b busy=%b want 0100 08 0000 0", rsp_vld, rsp_data, err, busy); errors++;
        end
        checks++;
        tick();
        if (rsp_vld !== '0 || rsp_data !== 8'h08) begin
            $display("FAIL single_hold got vld=%b data=%h want 0000 08", rsp_vld, rsp_data); errors++;
        end
        checks++;
        $display("single: port 2 result %h", rsp_data);
    endtask

    task automatic test_round_robin();
        logic [P-1:0] expv;
        int e;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int p = 0; p < P; p++) set_port(p, 4'(p + 1), 2'(p), 8'(8'h20 + p), 8'(8'h30 + p));
        req = 4'hF; alu_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = i % P;
            expv = 4'b0001 << e;
            tick();
            if (gnt !== expv || act !== 1'b1 || reg_a !== 8'(8'h20 + e)) begin
                $display("FAIL rr_gnt%0d got=%b act=%b a=%h want=%b 1 %h", i, gnt, act, reg_a, expv, 8'(8'h20 + e)); errors++;
            end
            checks++;
            tick();
            ex_alu_vld = 1'b1; ex_alu = 8'(8'h40 + i);
            tick();
            ex_alu_vld = 1'b0;
            if (i == 4) req = '0;
            if (rsp_vld !== expv || rsp_data !== 8'(8'h40 + i)) begin
                $display("FAIL rr_rsp%0d got=%b %h want=%b %h", i, rsp_vld, rsp_data, expv, 8'(8'h40 + i)); errors++;
            end
            checks++;
            $display("rr: grant %0d port %0d result %h", i, e, rsp_data);
        end
    endtask

    task automatic test_backpressure();
        req = 4'b0010; alu_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (act !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL bp_hold%0d got act=%b busy=%b want 0 0", i, act, busy); errors++;
            end
            checks++;
        end
        alu_rdy = 1'b1;
        tick();
        if (act !== 1'b1 || gnt !== 4'b0010) begin
            $display("FAIL bp_release got act=%b gnt=%b want 1 0010", act, gnt); errors++;
        end
        checks++;
        req = '0; alu_rdy = 1'b0;  // ignored outside IDLE
        tick();
        ex_alu_vld = 1'b1; ex_alu = 8'h55;
        tick();
        ex_alu_vld = 1'b0;
        if (rsp_vld !== 4'b0010 || rsp_data !== 8'h55) begin
            $display("FAIL bp_rsp got=%b %h want=0010 55", rsp_vld, rsp_data); errors++;
        end
        checks++;
        alu_rdy = 1'b1;
        $display("backpressure: port 1 result %h", rsp_data);
    endtask

    task automatic test_timeout();
        req = 4'b1000;
        tick();
        if (gnt !== 4'b1000) begin
            $display("FAIL to_gnt got=%b want=1000", gnt); errors++;
        end
        checks++;
        req = '0;
        for (int i = 1; i < TO + 1; i++) begin
            tick();
            if (err !== '0 || busy !== 1'b1) begin
                $display("FAIL to_early%0d got err=%b busy=%b want 0000 1", i, err, busy); errors++;
            end
            checks++;
        end
        tick();
        if (err !== 4'b1000 || rsp_vld !== '0 || busy !== 1'b0) begin
            $display("FAIL to_err got err=%b vld=%b busy=%b want 1000 0000 0", err, rsp_vld, busy); errors++;
        end
        checks++;
        tick();
        if (err !== '0) begin
            $display("FAIL to_err_pulse got=%b want=0000", err); errors++;
        end
        checks++;
        set_port(0, 4'h3, 2'b10, 8'h11, 8'h22);
        req = 4'b0001;
        tick();
        if (gnt !== 4'b0001 || reg_a !== 8'h11) begin
            $display("FAIL to_next got=%b %h want=0001 11", gnt, reg_a); errors++;
        end
        checks++;
        req = '0;
        tick();
        ex_alu_vld = 1'b1; ex_alu = 8'h33;
        tick();
        ex_alu_vld = 1'b0;
        if (rsp_vld !== 4'b0001 || rsp_data !== 8'h33) begin
            $display("FAIL to_next_rsp got=%b %h want=0001 33", rsp_vld, rsp_data); errors++;
        end
        checks++;
        $display("timeout: port 3 aborted, port 0 result %h", rsp_data);
    endtask

    task automatic test_stray_and_race();
        ex_alu_vld = 1'b1; ex_alu = 8'h99;
        tick();
        ex_alu_vld = 1'b0;
        tick();
        if (rsp_vld !== '0 || busy !== 1'b0 || rsp_data !== 8'h33) begin
            $display("FAIL stray got vld=%b busy=%b data=%h want 0000 0 33", rsp_vld, busy, rsp_data); errors++;
        end
        checks++;
        req = 4'b0010;
        tick();
        req = '0;
        for (int i = 0; i < TO; i++) tick();
        ex_alu_vld = 1'b1; ex_alu = 8'hA5;
        tick();
        ex_alu_vld = 1'b0;
        if (rsp_vld !== 4'b0010 || err !== '0 || rsp_data !== 8'hA5) begin
            $display("FAIL race got vld=%b err=%b data=%h want 0010 0000 a5", rsp_vld, err, rsp_data); errors++;
        end
        checks++;
        $display("race: result on timeout cycle %h", rsp_data);
    endtask

    task automatic test_reset_midop();
        set_port(2, 4'h7, 2'b11, 8'h44, 8'h66);
        req = 4'b0100;
        tick();
        req = '0;
        tick(); tick();
        rst = 1'b1;
        #1;
        if ({gnt, rsp_vld, err, busy, act} !== '0 || {op, movi, reg_a, reg_b, rsp_data} !== '0) begin
            $display("FAIL midrst got ctrl=%b data=%h want 0", {gnt, rsp_vld, err, busy, act}, {op, movi, reg_a, reg_b, rsp_data}); errors++;
        end
        checks++;
        tick();
        rst = 1'b0;
        ex_alu_vld = 1'b1; ex_alu = 8'h77;
        tick();
        ex_alu_vld = 1'b0;
        tick();
        if (rsp_vld !== '0 || err !== '0 || busy !== 1'b0) begin
            $display("FAIL midrst_stray got vld=%b err=%b busy=%b want 0000 0000 0", rsp_vld, err, busy); errors++;
        end
        checks++;
        req = 4'b0101;
        tick();
        if (gnt !== 4'b0001) begin
            $display("FAIL midrst_first got=%b want=0001", gnt); errors++;
        end
        checks++;
        req = 4'b0100;
        tick();
        ex_alu_vld = 1'b1; ex_alu = 8'h12;
        tick();
        ex_alu_vld = 1'b0;
        tick();
        if (gnt !== 4'b0100) begin
            $display("FAIL midrst_second got=%b want=0100", gnt); errors++;
        end
        checks++;
        req = '0;
        $display("reset mid-op: grants port 0 then port 2");
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_stray_and_race();
        test_reset_midop();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
